// File: rtl/vid_pkg.sv
// rtl/vid_pkg.sv - shared types and helpers for the video timing generator
//
// Purpose: pattern mode encoding, colour-bar lookup and timing-total helper
// used by vid_timing_cnt and vid_tpg_timing_gen.
// Optional build macro: VID_TPG_BORDER_EN (consumed by the other files).

package vid_pkg;

  typedef enum logic [1:0] {
    BARS   = 2'd0,
    RAMP   = 2'd1,
    SOLID  = 2'd2,
    SCROLL = 2'd3
  } vid_mode_e;

  // One bit per channel, ordered {r,g,b}; expanded to full depth by the user.
  typedef logic [2:0] bar_rgb_t;

  localparam int VID_NUM_BARS = 8;

  function automatic int vid_total(input int active, input int fp, input int sw, input int bp);
    return active + fp + sw + bp;
  endfunction

  // Index 0..7 gives white, yellow, cyan, green, magenta, red, blue, black.
  function automatic bar_rgb_t bar_color(input logic [2:0] idx);
    return {~idx[1], ~idx[2], ~idx[0]};
  endfunction

endpackage

// File: rtl/vid_timing_cnt.sv
// rtl/vid_timing_cnt.sv - horizontal/vertical raster counters and timing decodes
//
// Purpose: free-running h/v counters (held at 0,0 while disabled) with
// combinational decodes of the current counter position.
// Ports:
//   clk_i, rst_i, en_i  clock, async active-high reset, run enable
//   h_cnt_o             current horizontal position
//   hs_act_o, vs_act_o  position lies inside the h/v sync pulse
//   de_o                position lies inside the active area
//   sof_o               position is (0,0)
//   line_end_o          position is the last pixel of a line
//   frame_end_o         position is the last pixel of a frame
//   border_o            active-area edge pixel (only with VID_TPG_BORDER_EN)

module vid_timing_cnt
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SW     = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SW     = 5,
  parameter int V_BP     = 20,
  parameter int HW       = $clog2(vid_total(H_ACTIVE, H_FP, H_SW, H_BP) + 1),
  parameter int VW       = $clog2(vid_total(V_ACTIVE, V_FP, V_SW, V_BP) + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  output logic [HW-1:0] h_cnt_o,
  output logic          hs_act_o,
  output logic          vs_act_o,
  output logic          de_o,
  output logic          sof_o,
  output logic          line_end_o,
  output logic          frame_end_o
`ifdef VID_TPG_BORDER_EN
  ,
  output logic          border_o
`endif
);

  localparam int H_TOTAL = vid_total(H_ACTIVE, H_FP, H_SW, H_BP);
  localparam int V_TOTAL = vid_total(V_ACTIVE, V_FP, V_SW, V_BP);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SW);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SW);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  assign line_end_o  = (h_q == H_LAST);
  assign frame_end_o = line_end_o && (v_q == V_LAST);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!en_i) begin
      h_d = '0;
      v_d = '0;
    end else if (line_end_o) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt_o  = h_q;
  assign hs_act_o = (h_q >= HS_START) && (h_q < HS_END);
  // v_q only moves on line wrap, so vsync edges always land at h = 0.
  assign vs_act_o = (v_q >= VS_START) && (v_q < VS_END);
  assign de_o     = (h_q < H_ACT) && (v_q < V_ACT);
  assign sof_o    = (h_q == '0) && (v_q == '0);

`ifdef VID_TPG_BORDER_EN
  assign border_o = de_o && ((h_q == '0) || (h_q == H_ACT - 1'b1) ||
                             (v_q == '0) || (v_q == V_ACT - 1'b1));
`endif

endmodule

// File: rtl/vid_tpg_timing_gen.sv
// rtl/vid_tpg_timing_gen.sv - video timing generator with test pattern source
//
// Purpose: drives hsync/vsync/VDE and {r,g,b} pixel data for the HDMI encoder
// path; four pattern modes selected per frame.
// Optional build macro: VID_TPG_BORDER_EN (all-ones frame around active area).
// Ports:
//   PixelClk, rst, en   pixel clock, async active-high reset, run enable
//   mode, solid_rgb     pattern select and solid colour, sampled at frame start
//   vid_hsync/vsync     sync outputs with HSYNC_POL/VSYNC_POL active level
//   vid_VDE, vid_data   data enable and {r,g,b} pixel
//   vid_sof             pulse with the first active pixel of each frame
//   frame_cnt           completed-frame counter

module vid_tpg_timing_gen
  import vid_pkg::*;
#(
  parameter int VID_H_ACTIVE      = 1280,
  parameter int VID_H_FRONT_PORCH = 110,
  parameter int VID_H_SYNC_WIDTH  = 40,
  parameter int VID_H_BACK_PORCH  = 220,
  parameter int VID_V_ACTIVE      = 720,
  parameter int VID_V_FRONT_PORCH = 5,
  parameter int VID_V_SYNC_WIDTH  = 5,
  parameter int VID_V_BACK_PORCH  = 20,
  parameter bit HSYNC_POL         = 1'b1,
  parameter bit VSYNC_POL         = 1'b1,
  parameter int COLOR_DEPTH       = 8
) (
  input  logic                     PixelClk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic [3*COLOR_DEPTH-1:0] solid_rgb,
  output logic                     vid_hsync,
  output logic                     vid_vsync,
  output logic                     vid_VDE,
  output logic [3*COLOR_DEPTH-1:0] vid_data,
  output logic                     vid_sof,
  output logic [15:0]              frame_cnt
);

  localparam int D  = COLOR_DEPTH;
  localparam int HW = $clog2(vid_total(VID_H_ACTIVE, VID_H_FRONT_PORCH,
                                       VID_H_SYNC_WIDTH, VID_H_BACK_PORCH) + 1);
  localparam int VW = $clog2(vid_total(VID_V_ACTIVE, VID_V_FRONT_PORCH,
                                       VID_V_SYNC_WIDTH, VID_V_BACK_PORCH) + 1);
  localparam logic [HW-1:0] BAR_LAST = HW'(VID_H_ACTIVE / VID_NUM_BARS - 1);

  typedef logic [3*D-1:0] rgb_t;

  logic [HW-1:0] h_cnt;
  logic          hs_act, vs_act, de, sof, line_end, frame_end;
`ifdef VID_TPG_BORDER_EN
  logic          border;
`endif

  vid_timing_cnt #(
    .H_ACTIVE (VID_H_ACTIVE),
    .H_FP     (VID_H_FRONT_PORCH),
    .H_SW     (VID_H_SYNC_WIDTH),
    .H_BP     (VID_H_BACK_PORCH),
    .V_ACTIVE (VID_V_ACTIVE),
    .V_FP     (VID_V_FRONT_PORCH),
    .V_SW     (VID_V_SYNC_WIDTH),
    .V_BP     (VID_V_BACK_PORCH),
    .HW       (HW),
    .VW       (VW)
  ) u_cnt (
    .clk_i       (PixelClk),
    .rst_i       (rst),
    .en_i        (en),
    .h_cnt_o     (h_cnt),
    .hs_act_o    (hs_act),
    .vs_act_o    (vs_act),
    .de_o        (de),
    .sof_o       (sof),
    .line_end_o  (line_end),
    .frame_end_o (frame_end)
`ifdef VID_TPG_BORDER_EN
    ,
    .border_o    (border)
`endif
  );

  logic          hs_q, vs_q, de_q, sof_q;
  rgb_t          data_q, pix_d;
  logic [15:0]   frame_cnt_q, fscroll_q, fscroll_cur;
  vid_mode_e     mode_q, mode_cur;
  rgb_t          solid_q, solid_cur;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [HW-1:0] bar_pix_q, bar_pix_d;
  bar_rgb_t      bar_bits;
  logic [D-1:0]  ramp, scroll;

  always_comb begin
    // At (0,0) the fresh inputs are used directly so the first pixel already
    // reflects the newly latched frame settings.
    mode_cur    = sof ? vid_mode_e'(mode) : mode_q;
    solid_cur   = sof ? solid_rgb : solid_q;
    fscroll_cur = sof ? frame_cnt_q : fscroll_q;
    bar_bits    = bar_color(bar_idx_q);
    ramp        = D'(h_cnt);
    scroll      = D'(32'(h_cnt) + 32'(fscroll_cur));

    case (mode_cur)
      BARS:    pix_d = {{D{bar_bits[2]}}, {D{bar_bits[1]}}, {D{bar_bits[0]}}};
      RAMP:    pix_d = {3{ramp}};
      SOLID:   pix_d = solid_cur;
      default: pix_d = {3{scroll}};
    endcase
`ifdef VID_TPG_BORDER_EN
    if (border) pix_d = '1;
`endif
    if (!de) pix_d = '0;

    // Bar counter tracks h_cnt: index steps every BAR_W pixels and sticks at 7
    // so any H_ACTIVE % 8 remainder shows the last bar.
    bar_idx_d = bar_idx_q;
    bar_pix_d = bar_pix_q + 1'b1;
    if (line_end) begin
      bar_idx_d = '0;
      bar_pix_d = '0;
    end else if (bar_pix_q == BAR_LAST) begin
      bar_pix_d = '0;
      if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
    end
  end

  always_ff @(posedge PixelClk or posedge rst) begin
    if (rst) begin
      hs_q        <= ~HSYNC_POL;
      vs_q        <= ~VSYNC_POL;
      de_q        <= 1'b0;
      data_q      <= '0;
      sof_q       <= 1'b0;
      frame_cnt_q <= '0;
      mode_q      <= BARS;
      solid_q     <= '0;
      fscroll_q   <= '0;
      bar_idx_q   <= '0;
      bar_pix_q   <= '0;
    end else if (!en) begin
      hs_q      <= ~HSYNC_POL;
      vs_q      <= ~VSYNC_POL;
      de_q      <= 1'b0;
      data_q    <= '0;
      sof_q     <= 1'b0;
      bar_idx_q <= '0;
      bar_pix_q <= '0;
    end else begin
      hs_q      <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vs_q      <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      de_q      <= de;
      data_q    <= pix_d;
      sof_q     <= sof;
      mode_q    <= mode_cur;
      solid_q   <= solid_cur;
      fscroll_q <= fscroll_cur;
      bar_idx_q <= bar_idx_d;
      bar_pix_q <= bar_pix_d;
      if (frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign vid_hsync = hs_q;
  assign vid_vsync = vs_q;
  assign vid_VDE   = de_q;
  assign vid_data  = data_q;
  assign vid_sof   = sof_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vid_tpg_timing_gen.sv
// tb/tb_vid_tpg_timing_gen.sv - self-checking bench for vid_tpg_timing_gen

module tb_vid_tpg_timing_gen;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;

  logic        hs, vs, de, sof;
  logic [23:0] data;
  logic [15:0] fcnt;
  logic        n_hs, n_vs, n_de, n_sof;
  logic [23:0] n_data;
  logic [15:0] n_fcnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vid_tpg_timing_gen #(
    .VID_H_ACTIVE(16), .VID_H_FRONT_PORCH(2), .VID_H_SYNC_WIDTH(3), .VID_H_BACK_PORCH(3),
    .VID_V_ACTIVE(4), .VID_V_FRONT_PORCH(1), .VID_V_SYNC_WIDTH(2), .VID_V_BACK_PORCH(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COLOR_DEPTH(8)
  ) u_dut (
    .PixelClk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .vid_hsync(hs), .vid_vsync(vs), .vid_VDE(de), .vid_data(data),
    .vid_sof(sof), .frame_cnt(fcnt)
  );

  vid_tpg_timing_gen #(
    .VID_H_ACTIVE(16), .VID_H_FRONT_PORCH(2), .VID_H_SYNC_WIDTH(3), .VID_H_BACK_PORCH(3),
    .VID_V_ACTIVE(4), .VID_V_FRONT_PORCH(1), .VID_V_SYNC_WIDTH(2), .VID_V_BACK_PORCH(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_DEPTH(8)
  ) u_dut_n (
    .PixelClk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .vid_hsync(n_hs), .vid_vsync(n_vs), .vid_VDE(n_de), .vid_data(n_data),
    .vid_sof(n_sof), .frame_cnt(n_fcnt)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [23:0] solid;
    logic [1:0]  mid_mode;
    logic [23:0] mid_solid;
    logic [23:0] px0;
    logic [23:0] px15;
  } frame_vec_t;

  frame_vec_t  fv[8];
  logic [23:0] bar_line[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          h, v;
  logic        e_de, e_hs, e_vs;
  logic [23:0] exp_d;

  initial begin
    bar_line = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00,
                 24'h00FFFF, 24'h00FFFF, 24'h00FF00, 24'h00FF00,
                 24'hFF00FF, 24'hFF00FF, 24'hFF0000, 24'hFF0000,
                 24'h0000FF, 24'h0000FF, 24'h000000, 24'h000000};
    fv[0] = '{2'd0, 24'h000000, 2'd0, 24'h000000, 24'hFFFFFF, 24'h000000};
    fv[1] = '{2'd0, 24'h000000, 2'd2, 24'h654321, 24'hFFFFFF, 24'h000000};
    fv[2] = '{2'd2, 24'h123456, 2'd2, 24'hABCDEF, 24'h123456, 24'h123456};
    fv[3] = '{2'd2, 24'hABCDEF, 2'd0, 24'h111111, 24'hABCDEF, 24'hABCDEF};
    fv[4] = '{2'd1, 24'h000000, 2'd3, 24'h000000, 24'h000000, 24'h0F0F0F};
    fv[5] = '{2'd3, 24'h000000, 2'd1, 24'h000000, 24'h050505, 24'h141414};
    fv[6] = '{2'd3, 24'h000000, 2'd2, 24'h222222, 24'h060606, 24'h151515};
    fv[7] = '{2'd3, 24'h000000, 2'd0, 24'h000000, 24'h070707, 24'h161616};

    rst = 1'b1; en = 1'b0; mode = 2'd0; solid_rgb = 24'h0;
    tick(); tick();
    chk("reset hsync", 32'(hs), 32'd0);
    chk("reset vsync", 32'(vs), 32'd0);
    chk("reset VDE", 32'(de), 32'd0);
    chk("reset data", 32'(data), 32'd0);
    chk("reset sof", 32'(sof), 32'd0);
    chk("reset frame_cnt", 32'(fcnt), 32'd0);
    chk("reset n_hsync", 32'(n_hs), 32'd1);
    chk("reset n_vsync", 32'(n_vs), 32'd1);

    rst = 1'b0; en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      mode = fv[f].mode;
      solid_rgb = fv[f].solid;
      for (int c = 0; c < 192; c++) begin
        if (c == 100) begin
          mode = fv[f].mid_mode;
          solid_rgb = fv[f].mid_solid;
        end
        tick();
        h = c % 24;
        v = c / 24;
        e_de = (h < 16) && (v < 4);
        e_hs = (h >= 18) && (h < 21);
        e_vs = (v >= 5) && (v < 7);
        case (fv[f].mode)
          2'd0:    exp_d = bar_line[h % 16];
          2'd1:    exp_d = {3{8'(h)}};
          2'd2:    exp_d = fv[f].solid;
          default: exp_d = {3{8'(h + f)}};
        endcase
        if (!e_de) exp_d = '0;
        chk($sformatf("hsync f%0d c%0d", f, c), 32'(hs), 32'(e_hs));
        chk($sformatf("vsync f%0d c%0d", f, c), 32'(vs), 32'(e_vs));
        chk($sformatf("VDE f%0d c%0d", f, c), 32'(de), 32'(e_de));
        chk($sformatf("sof f%0d c%0d", f, c), 32'(sof), 32'(c == 0));
        chk($sformatf("data f%0d c%0d", f, c), 32'(data), 32'(exp_d));
        chk($sformatf("frame_cnt f%0d c%0d", f, c), 32'(fcnt), 32'((c == 191) ? f + 1 : f));
        chk($sformatf("n_hsync f%0d c%0d", f, c), 32'(n_hs), 32'(!e_hs));
        chk($sformatf("n_vsync f%0d c%0d", f, c), 32'(n_vs), 32'(!e_vs));
        chk($sformatf("n_VDE f%0d c%0d", f, c), 32'(n_de), 32'(e_de));
        if (v == 0 && h == 0)
          chk($sformatf("px0 f%0d", f), 32'(data), 32'(fv[f].px0));
        if (v == 0 && h == 15)
          chk($sformatf("px15 f%0d", f), 32'(data), 32'(fv[f].px15));
      end
    end

    // En gated low mid-line: outputs idle, frame counter frozen.
    mode = 2'd1;
    repeat (30) tick();
    chk("pre-gate VDE", 32'(de), 32'd1);
    chk("pre-gate data", 32'(data), 32'h050505);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("gated hsync %0d", i), 32'(hs), 32'd0);
      chk($sformatf("gated n_hsync %0d", i), 32'(n_hs), 32'd1);
      chk($sformatf("gated n_vsync %0d", i), 32'(n_vs), 32'd1);
      chk($sformatf("gated VDE %0d", i), 32'(de), 32'd0);
      chk($sformatf("gated data %0d", i), 32'(data), 32'd0);
      chk($sformatf("gated sof %0d", i), 32'(sof), 32'd0);
      chk($sformatf("gated frame_cnt %0d", i), 32'(fcnt), 32'd8);
    end
    en = 1'b1;
    tick();
    chk("reen sof", 32'(sof), 32'd1);
    chk("reen VDE", 32'(de), 32'd1);
    chk("reen data", 32'(data), 32'h000000);
    chk("reen frame_cnt", 32'(fcnt), 32'd8);
    tick();
    chk("reen sof2", 32'(sof), 32'd0);
    chk("reen data2", 32'(data), 32'h010101);
    repeat (4) tick();
    chk("pre-rst VDE", 32'(de), 32'd1);
    chk("pre-rst data", 32'(data), 32'h050505);

    // Asynchronous reset mid-frame, checked before the next clock edge.
    rst = 1'b1;
    #1;
    chk("async rst VDE", 32'(de), 32'd0);
    chk("async rst data", 32'(data), 32'd0);
    chk("async rst frame_cnt", 32'(fcnt), 32'd0);
    chk("async rst hsync", 32'(hs), 32'd0);
    chk("async rst n_hsync", 32'(n_hs), 32'd1);
    chk("async rst n_vsync", 32'(n_vs), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("restart sof", 32'(sof), 32'd1);
    chk("restart VDE", 32'(de), 32'd1);
    chk("restart data", 32'(data), 32'h000000);
    tick(); tick();
    chk("restart px2", 32'(data), 32'h020202);
    chk("restart frame_cnt", 32'(fcnt), 32'd0);
    repeat (189) tick();
    chk("restart frame done", 32'(fcnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
